fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, a one-deep fetch buffer fed by a
// variable-latency instruction memory, and the IF/ID pipeline register.
// At most one memory read is outstanding at any time. A redirect from Execute
// can arrive at any point in the read, so a read that is still in flight when
// a redirect arrives is drained and its data thrown away.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  // hazard unit controls
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  // redirect from Execute
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  // instruction memory read port
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  // IF/ID register
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusyF
);

  // IDLE  : ready to issue a read for PCF
  // WAIT  : read outstanding, data still wanted
  // READY : fetch buffer holds the instruction at PCF
  // DRAIN : read outstanding, data no longer wanted (redirected meanwhile)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  state_t      state;
  state_t      state_next;
  logic [31:0] pcf;
  logic [31:0] pcf_next;
  logic [31:0] pcf_plus4;
  logic [31:0] redirect_pc;
  logic [31:0] fb_instr;
  logic [31:0] fb_pc;
  logic        fb_load;
  logic        transfer;
  logic        req_raw;

  // Targets are forced word-aligned; the +4 wraps naturally at 2^32.
  assign redirect_pc = {PCTargetE[31:2], 2'b00};
  assign pcf_plus4   = pcf + PC_STEP;

  // Next-state, next-PC and buffer/transfer strobes.
  // NOTE: every output of this block gets a default first so no path can leave
  // a value unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_next = state;
    pcf_next   = pcf;
    fb_load    = 1'b0;
    transfer   = 1'b0;
    req_raw    = 1'b0;
    unique case (state)
      IDLE: begin
        if (PCSrcE) begin
          pcf_next = redirect_pc;
        end else begin
          req_raw    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (PCSrcE) begin
          pcf_next   = redirect_pc;
          // Data arriving with the redirect is stale; nothing left in flight.
          state_next = ImemRValid ? IDLE : DRAIN;
        end else if (ImemRValid) begin
          fb_load    = 1'b1;
          state_next = READY;
        end
      end
      DRAIN: begin
        if (PCSrcE) begin
          pcf_next = redirect_pc;
        end
        if (ImemRValid) begin
          state_next = IDLE;
        end
      end
      READY: begin
        if (PCSrcE) begin
          pcf_next   = redirect_pc;
          state_next = IDLE;
        end else if (!StallF && !StallD) begin
          transfer   = 1'b1;
          pcf_next   = pcf_plus4;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, PC and fetch buffer registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcf      <= RESET_PC;
      fb_instr <= '0;
      fb_pc    <= '0;
    end else begin
      state <= state_next;
      pcf   <= pcf_next;
      if (fb_load) begin
        fb_instr <= ImemRData;
        fb_pc    <= pcf;
      end
    end
  end

  // IF/ID register: flush beats stall beats transfer; otherwise a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (transfer) begin
      InstrD   <= fb_instr;
      PCD      <= fb_pc;
      PCPlus4D <= fb_pc + PC_STEP;
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end
  end

  // The request is gated by reset so nothing is issued while rst_n is low.
  assign ImemReq    = req_raw & rst_n;
  assign ImemAddr   = pcf;
  assign FetchBusyF = (state != READY);

endmodule
